// File: rtl/io_function_decode_read_block.sv
// io_function_decode_read_block
// CPU-side read path for the 32-word IO register block. A CPU read strobe
// that hits the block either gets an immediate DEFAULT_DATA response
// (unmapped offset) or causes a one-cycle read enable to the selected
// peripheral, followed by a bounded wait for that peripheral's ack.
//
// Handshake: the CPU issues a single-cycle io_rd with cpu_addr. A mapped hit
// raises cpu_wait on the next cycle, and cpu_wait stays high until the
// response cycle. The response is a single cycle with cpu_rd_valid high and
// cpu_dout carrying the data. A strobe seen outside IDLE is dropped. On the
// peripheral side, re_x is a one-cycle request, and ack_x is sampled on each
// edge while waiting. Only the selected peripheral's ack is considered.
//
// All outputs come straight from flops. The combinational process only
// computes next-state values.
module io_function_decode_read_block #(
  parameter int                      DATA_WIDTH     = 16,
  parameter int                      ADDRESS_WIDTH  = 16,
  parameter int                      BLOCK_SIZE     = 5,
  parameter logic [ADDRESS_WIDTH-1:0] IO_BASE_ADDR  = 16'h1000,
  parameter logic [ADDRESS_WIDTH-1:0] IO_BASE_MASK  = {ADDRESS_WIDTH{1'b1}} << BLOCK_SIZE,
  parameter int                      TIMEOUT_CYCLES = 15,
  parameter logic [DATA_WIDTH-1:0]   DEFAULT_DATA   = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic                     io_rd,
  input  logic [DATA_WIDTH-1:0]    io_din_0,
  input  logic [DATA_WIDTH-1:0]    io_din_1,
  input  logic                     ack_0,
  input  logic                     ack_1,
  input  logic                     timeout_clr,
  output logic                     re_0,
  output logic                     re_1,
  output logic [DATA_WIDTH-1:0]    cpu_dout,
  output logic                     cpu_rd_valid,
  output logic                     cpu_wait,
  output logic                     timeout_flag
);

  // Counter is wide enough to hold TIMEOUT_CYCLES; a zero load is not legal.
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_LOAD = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]         CNT_ZERO = '0;
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [BLOCK_SIZE-1:0] OFF_ZERO = '0;
  localparam logic [BLOCK_SIZE-1:0] OFF_ONE  = BLOCK_SIZE'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t                  state;
  state_t                  state_next;

  logic [BLOCK_SIZE-1:0]   offset_q;
  logic [BLOCK_SIZE-1:0]   offset_next;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_next;

  logic                    re_0_next;
  logic                    re_1_next;
  logic [DATA_WIDTH-1:0]   cpu_dout_next;
  logic                    cpu_rd_valid_next;
  logic                    cpu_wait_next;
  logic                    timeout_set;
  logic                    timeout_flag_next;

  logic                    hit;
  logic [BLOCK_SIZE-1:0]   offset_in;
  logic                    offset_in_mapped;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_din;

  // Address decode and the selected peripheral's ack/data. Only offsets 0
  // and 1 ever reach WAIT, so offset_q picks between the two peripherals.
  always_comb begin
    hit              = io_rd && ((cpu_addr & IO_BASE_MASK) == IO_BASE_ADDR);
    offset_in        = cpu_addr[BLOCK_SIZE-1:0];
    offset_in_mapped = (offset_in == OFF_ZERO) || (offset_in == OFF_ONE);
    sel_ack          = (offset_q == OFF_ONE) ? ack_1 : ack_0;
    sel_din          = (offset_q == OFF_ONE) ? io_din_1 : io_din_0;
  end

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_next        = state;
    offset_next       = offset_q;
    count_next        = count_q;
    re_0_next         = 1'b0;
    re_1_next         = 1'b0;
    cpu_dout_next     = cpu_dout;
    cpu_rd_valid_next = 1'b0;
    cpu_wait_next     = cpu_wait;
    timeout_set       = 1'b0;

    case (state)
      IDLE: begin
        if (hit) begin
          offset_next = offset_in;
          if (offset_in_mapped) begin
            // re pulse is launched here so it is high during the ISSUE cycle.
            state_next    = ISSUE;
            count_next    = CNT_LOAD;
            cpu_wait_next = 1'b1;
            re_0_next     = (offset_in == OFF_ZERO);
            re_1_next     = (offset_in == OFF_ONE);
          end else begin
            // Unmapped offset answers right away without touching a peripheral.
            state_next        = RESP;
            cpu_dout_next     = DEFAULT_DATA;
            cpu_rd_valid_next = 1'b1;
            cpu_wait_next     = 1'b0;
          end
        end
      end

      ISSUE: begin
        // The counter is deliberately not touched here; the ack window starts
        // with the first WAIT cycle.
        state_next = WAIT;
      end

      WAIT: begin
        if (sel_ack) begin
          // Ack beats an expiring counter on the same edge.
          state_next        = RESP;
          cpu_dout_next     = sel_din;
          cpu_rd_valid_next = 1'b1;
          cpu_wait_next     = 1'b0;
        end else if (count_q == CNT_ZERO) begin
          state_next        = RESP;
          cpu_dout_next     = DEFAULT_DATA;
          cpu_rd_valid_next = 1'b1;
          cpu_wait_next     = 1'b0;
          timeout_set       = 1'b1;
        end else begin
          count_next = count_q - CNT_ONE;
        end
      end

      RESP: begin
        // Any strobe landing on the response cycle is dropped.
        state_next = IDLE;
      end

      default: begin
        state_next    = IDLE;
        cpu_wait_next = 1'b0;
      end
    endcase

    // Sticky flag: a set on the same edge as a clear takes priority.
    timeout_flag_next = timeout_set | (timeout_flag & ~timeout_clr);
  end

  // State register and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      offset_q     <= '0;
      count_q      <= '0;
      re_0         <= 1'b0;
      re_1         <= 1'b0;
      cpu_dout     <= '0;
      cpu_rd_valid <= 1'b0;
      cpu_wait     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_next;
      offset_q     <= offset_next;
      count_q      <= count_next;
      re_0         <= re_0_next;
      re_1         <= re_1_next;
      cpu_dout     <= cpu_dout_next;
      cpu_rd_valid <= cpu_rd_valid_next;
      cpu_wait     <= cpu_wait_next;
      timeout_flag <= timeout_flag_next;
    end
  end

endmodule

// File: tb/tb_io_function_decode_read_block.sv
// tb_io_function_decode_read_block
// Each read runs in a fixed 21-cycle window. Cycle c is the cycle whose
// closing rising edge is edge c, and the strobe is driven in cycle 0. Outputs
// are sampled at the falling edge inside each cycle, and inputs for that cycle
// are driven right after the sample. Per-cycle activity is gathered into
// bit masks and compared against masks built from the expected response.
module tb_io_function_decode_read_block;

  localparam int T    = 15;
  localparam int NCYC = 21;
  localparam logic [15:0] DEF = 16'h0000;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        io_rd;
  logic [15:0] io_din_0;
  logic [15:0] io_din_1;
  logic        ack_0;
  logic        ack_1;
  logic        timeout_clr;
  logic        re_0;
  logic        re_1;
  logic [15:0] cpu_dout;
  logic        cpu_rd_valid;
  logic        cpu_wait;
  logic        timeout_flag;

  int n_cmp = 0;
  int n_err = 0;

  logic        model_flag;
  logic [15:0] last_dout;

  // One read: stimulus fields followed by the expected response.
  typedef struct {
    logic [15:0] addr;
    int          a0;        // cycle of ack_0 pulse, -1 = none
    int          a1;        // cycle of ack_1 pulse, -1 = none
    logic [15:0] d0;
    logic [15:0] d1;
    int          clr;       // cycle of timeout_clr pulse, -1 = none
    int          rd2;       // cycle of a second (busy) strobe, -1 = none
    logic [15:0] rd2_addr;
    int          vcyc;      // expected valid cycle, -1 = no response
    logic [15:0] data;      // expected data on valid
    int          re0c;      // expected re_0 cycle, -1 = none
    int          re1c;      // expected re_1 cycle, -1 = none
    logic        flag;      // expected timeout_flag at end of window
  } vec_t;

  vec_t tbl[14];

  io_function_decode_read_block dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .io_rd        (io_rd),
    .io_din_0     (io_din_0),
    .io_din_1     (io_din_1),
    .ack_0        (ack_0),
    .ack_1        (ack_1),
    .timeout_clr  (timeout_clr),
    .re_0         (re_0),
    .re_1         (re_1),
    .cpu_dout     (cpu_dout),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_wait     (cpu_wait),
    .timeout_flag (timeout_flag)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    io_rd       = 1'b0;
    cpu_addr    = 16'h0000;
    ack_0       = 1'b0;
    ack_1       = 1'b0;
    timeout_clr = 1'b0;
  endtask

  // Reference behaviour of one read, from the block's rules. The result is
  // expressed as arrival cycles, not as FSM state.
  function automatic vec_t model(input vec_t v, input logic prior);
    vec_t r;
    logic hit;
    int   off;
    int   a;
    r      = v;
    hit    = ((v.addr & 16'hFFE0) == 16'h1000);
    off    = int'(v.addr & 16'h001F);
    r.re0c = -1;
    r.re1c = -1;
    r.data = last_dout;
    r.flag = (v.clr >= 0) ? 1'b0 : prior;
    if (!hit) begin
      r.vcyc = -1;
    end else if (off > 1) begin
      r.vcyc = 1;
      r.data = DEF;
    end else begin
      if (off == 0) r.re0c = 1;
      else          r.re1c = 1;
      a = (off == 1) ? v.a1 : v.a0;
      if (a >= 2 && a <= T + 2) begin
        r.vcyc = a + 1;
        r.data = (off == 1) ? v.d1 : v.d0;
      end else begin
        r.vcyc = T + 3;
        r.data = DEF;
        r.flag = (v.clr > T + 2) ? 1'b0 : 1'b1;
      end
    end
    return r;
  endfunction

  // Drive one read window and compare everything seen against v's expectations.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] m_re0, m_re1, m_val, m_wait;
    logic [31:0] e_re0, e_re1, e_val, e_wait;
    logic [15:0] dv;
    logic [15:0] exp_end;
    m_re0 = '0; m_re1 = '0; m_val = '0; m_wait = '0;
    dv = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (re_0)         m_re0[c]  = 1'b1;
      if (re_1)         m_re1[c]  = 1'b1;
      if (cpu_wait)     m_wait[c] = 1'b1;
      if (cpu_rd_valid) begin
        m_val[c] = 1'b1;
        dv       = cpu_dout;
      end
      io_rd       = (c == 0) || (c == v.rd2);
      cpu_addr    = (c == v.rd2) ? v.rd2_addr : v.addr;
      io_din_0    = v.d0;
      io_din_1    = v.d1;
      ack_0       = (c == v.a0);
      ack_1       = (c == v.a1);
      timeout_clr = (c == v.clr);
    end
    idle_inputs();

    e_re0  = (v.re0c >= 0) ? (32'd1 << v.re0c) : 32'd0;
    e_re1  = (v.re1c >= 0) ? (32'd1 << v.re1c) : 32'd0;
    e_val  = (v.vcyc >= 0) ? (32'd1 << v.vcyc) : 32'd0;
    e_wait = '0;
    if (v.re0c >= 0 || v.re1c >= 0)
      for (int c = 1; c < v.vcyc; c++) e_wait[c] = 1'b1;

    check({tag, "_re0"},   m_re0,  e_re0);
    check({tag, "_re1"},   m_re1,  e_re1);
    check({tag, "_valid"}, m_val,  e_val);
    check({tag, "_wait"},  m_wait, e_wait);
    if (v.vcyc >= 0) check({tag, "_data"}, {16'h0, dv}, {16'h0, v.data});
    exp_end = (v.vcyc >= 0) ? v.data : last_dout;
    check({tag, "_dout_hold"}, {16'h0, cpu_dout}, {16'h0, exp_end});
    check({tag, "_flag"}, {31'h0, timeout_flag}, {31'h0, v.flag});
    last_dout  = exp_end;
    model_flag = v.flag;
  endtask

  initial begin
    vec_t v;
    int   kind;

    // addr, a0, a1, d0, d1, clr, rd2, rd2_addr | vcyc, data, re0c, re1c, flag
    tbl[0]  = '{16'h1000,  2, -1, 16'hA5C3, 16'h0000, -1, -1, 16'h0000,  3, 16'hA5C3,  1, -1, 1'b0};
    tbl[1]  = '{16'h1001,  4,  7, 16'h1111, 16'h5A5A, -1, -1, 16'h0000,  8, 16'h5A5A, -1,  1, 1'b0};
    tbl[2]  = '{16'h1005, -1, -1, 16'h1111, 16'h2222, -1, -1, 16'h0000,  1, 16'h0000, -1, -1, 1'b0};
    tbl[3]  = '{16'h2000,  2,  2, 16'h1111, 16'h2222, -1, -1, 16'h0000, -1, 16'h0000, -1, -1, 1'b0};
    tbl[4]  = '{16'h1000, -1, -1, 16'h3333, 16'h4444, -1, -1, 16'h0000, 18, 16'h0000,  1, -1, 1'b1};
    tbl[5]  = '{16'h1001, -1,  3, 16'h3333, 16'hBEEF, -1, -1, 16'h0000,  4, 16'hBEEF, -1,  1, 1'b1};
    tbl[6]  = '{16'h1000, -1, -1, 16'h3333, 16'h4444, 17, -1, 16'h0000, 18, 16'h0000,  1, -1, 1'b1};
    tbl[7]  = '{16'h2000, -1, -1, 16'h3333, 16'h4444,  3, -1, 16'h0000, -1, 16'h0000, -1, -1, 1'b0};
    tbl[8]  = '{16'h1000, 17, -1, 16'hC0DE, 16'h4444, -1, -1, 16'h0000, 18, 16'hC0DE,  1, -1, 1'b0};
    tbl[9]  = '{16'h1000,  5, -1, 16'h1234, 16'h4444, -1,  3, 16'h1001,  6, 16'h1234,  1, -1, 1'b0};
    tbl[10] = '{16'h1000, 18, -1, 16'h9999, 16'h4444, -1, -1, 16'h0000, 18, 16'h0000,  1, -1, 1'b1};
    tbl[11] = '{16'h101F, -1, -1, 16'h9999, 16'h4444, -1,  1, 16'h1000,  1, 16'h0000, -1, -1, 1'b1};
    tbl[12] = '{16'h1020,  2, -1, 16'h9999, 16'h4444, -1, -1, 16'h0000, -1, 16'h0000, -1, -1, 1'b1};
    tbl[13] = '{16'h1000,  1, -1, 16'h9999, 16'h4444, 19, -1, 16'h0000, 18, 16'h0000,  1, -1, 1'b0};

    // Reset block
    idle_inputs();
    io_din_0   = '0;
    io_din_1   = '0;
    model_flag = 1'b0;
    last_dout  = 16'h0000;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'h0, cpu_rd_valid}, 32'h0);
    check("reset_wait",  {31'h0, cpu_wait},     32'h0);
    check("reset_re",    {30'h0, re_1, re_0},   32'h0);
    check("reset_flag",  {31'h0, timeout_flag}, 32'h0);
    check("reset_dout",  {16'h0, cpu_dout},     32'h0);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Randomized reads against the reference model
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       v.addr = 16'h1000;
        1:       v.addr = 16'h1001;
        2:       v.addr = 16'h1000 | 16'($urandom_range(0, 31));
        default: v.addr = 16'($urandom_range(0, 16'hFFFF));
      endcase
      v.a0       = int'($urandom_range(0, 20)) - 1;
      v.a1       = int'($urandom_range(0, 20)) - 1;
      v.d0       = 16'($urandom);
      v.d1       = 16'($urandom);
      v.clr      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 19)) : -1;
      v.rd2      = -1;
      v.rd2_addr = 16'h1000 | 16'($urandom_range(0, 1));
      v = model(v, model_flag);
      if (v.vcyc >= 1 && $urandom_range(0, 1) == 1)
        v.rd2 = int'($urandom_range(1, v.vcyc));
      apply(v, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-WAIT: first leave a set flag and non-zero data behind.
    v = '{16'h1000, -1, -1, 16'h0, 16'h0, -1, -1, 16'h0, 18, 16'h0000, 1, -1, 1'b1};
    apply(v, "pre_rst_timeout");
    v = '{16'h1001, -1, 6, 16'h0, 16'h7777, -1, -1, 16'h0, 7, 16'h7777, -1, 1, 1'b1};
    apply(v, "pre_rst_read");

    @(negedge clk);
    io_rd    = 1'b1;
    cpu_addr = 16'h1000;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("mid_wait_busy", {31'h0, cpu_wait}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, cpu_rd_valid}, 32'h0);
    check("async_rst_wait",  {31'h0, cpu_wait},     32'h0);
    check("async_rst_re",    {30'h0, re_1, re_0},   32'h0);
    check("async_rst_flag",  {31'h0, timeout_flag}, 32'h0);
    check("async_rst_dout",  {16'h0, cpu_dout},     32'h0);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    model_flag = 1'b0;
    last_dout  = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", c), {30'h0, cpu_rd_valid, cpu_wait}, 32'h0);
    end
    v = '{16'h1000, 2, -1, 16'hA5C3, 16'h0, -1, -1, 16'h0, 3, 16'hA5C3, 1, -1, 1'b0};
    apply(v, "post_rst_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_function_decode_read_block.md
Name: io_function_decode_read_block

Overview:
CPU-side read path for the 32-word IO register block at IO_BASE_ADDR. It is the counterpart to the IO write decode block. It decodes a CPU read strobe, issues a one-cycle read enable to the selected peripheral register, and waits for that peripheral's acknowledge, bounded by a timeout. It then returns the data with a valid pulse and holds the CPU in wait while the transfer is outstanding. Single clock domain; peripherals on the other side are already synchronous to clk.

Parameters:
DATA_WIDTH, 16, data bus width
ADDRESS_WIDTH, 16, CPU address width
BLOCK_SIZE, 5, offset bits inside IO block (32 words)
IO_BASE_ADDR, 16'h1000, block base address
IO_BASE_MASK, 16'hFFFF << BLOCK_SIZE, base compare mask
TIMEOUT_CYCLES, 15, max counter load for ack wait; must be >= 1
DEFAULT_DATA, 16'h0000, data returned on timeout or unmapped offset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
cpu_addr  in  ADDRESS_WIDTH  CPU address, sampled with io_rd
io_rd  in  1  CPU read strobe, single-cycle
io_din_0  in  DATA_WIDTH  read data, offset 0 peripheral
io_din_1  in  DATA_WIDTH  read data, offset 1 peripheral
ack_0  in  1  data-ready from offset 0 peripheral
ack_1  in  1  data-ready from offset 1 peripheral
timeout_clr  in  1  clears timeout_flag
re_0  out  1  read enable pulse, offset 0
re_1  out  1  read enable pulse, offset 1
cpu_dout  out  DATA_WIDTH  read data to CPU, registered
cpu_rd_valid  out  1  one-cycle pulse: cpu_dout valid
cpu_wait  out  1  transfer outstanding; CPU stalls
timeout_flag  out  1  sticky: a read timed out

Behaviour:
- Decode: hit = io_rd & ((cpu_addr & IO_BASE_MASK) == IO_BASE_ADDR). The CPU address offset cpu_addr[BLOCK_SIZE-1:0] is latched on a hit in IDLE.
- Reset (rst low, async): state IDLE; re_0, re_1, cpu_rd_valid, cpu_wait and timeout_flag are 0; cpu_dout is 0; counter is 0. Reset mid-transfer aborts the transfer with no valid pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, hit with offset 0 or 1: go to ISSUE. Load counter = TIMEOUT_CYCLES, set cpu_wait = 1.
- IDLE, hit with any other offset: go to RESP, cpu_dout = DEFAULT_DATA, no re pulse. cpu_wait stays 0.
- IDLE, no hit: stay in IDLE.
- ISSUE: re_x = 1 for exactly this cycle, for the latched offset only. Go to WAIT.
- WAIT: sample the selected peripheral's ack on each edge.
  - Selected ack high: cpu_dout <= io_din_x, go to RESP.
  - Else, counter == 0: cpu_dout <= DEFAULT_DATA, set timeout_flag, go to RESP.
  - Else: decrement the counter.
  - The unselected peripheral's ack is ignored.
  - Ack and counter == 0 on the same edge: ack wins, no timeout.
- RESP: cpu_rd_valid = 1 and cpu_wait = 0 for this one cycle. Go to IDLE.
- io_rd while not in IDLE, including in RESP, is ignored. There is no queueing; the CPU must not strobe while cpu_wait is high.
- Latency (strobe sampled at edge 0):
  - re_x high in cycle 1.
  - Fastest mapped read: ack high in cycle 2 gives valid in cycle 3.
  - Unmapped offset: valid in cycle 1.
  - Timeout: ack is sampled in WAIT cycles 2 .. TIMEOUT_CYCLES+2; valid in cycle TIMEOUT_CYCLES+3 (cycle 18 at default).
- cpu_dout holds its last value between RESP cycles.
- timeout_flag is sticky; timeout_clr clears it. If set and clear occur on the same edge, set wins.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter never wraps; it stops at 0.

Test Plan:
- Reset: rst low asynchronously mid-WAIT → all outputs 0 immediately; after release, the next read works normally.
- Mapped read, offset 0: addr 16'h1000 with io_rd, ack_0 high in cycle 2 with io_din_0 = 16'hA5C3 → re_0 high in cycle 1 only; cpu_wait high in cycles 1–2; cpu_rd_valid high in cycle 3 with cpu_dout = 16'hA5C3; re_1 never high.
- Offset 1 with a late ack: addr 16'h1001, ack_1 in cycle 7 and ack_0 pulsed in cycle 4 → ack_0 ignored; cpu_dout = io_din_1 and valid in cycle 8.
- Unmapped and miss: addr 16'h1005 → valid in cycle 1 with data 16'h0000 and no re pulse; addr 16'h2000 → no response.
- Timeout: addr 16'h1000, no ack → valid in cycle 18 with DEFAULT_DATA; timeout_flag set.
- Timeout flag priority: timeout_clr pulsed on the timeout edge → flag stays set; a later timeout_clr clears it.
- Ack/timeout race: ack_0 high exactly in cycle 17 → data returned, timeout_flag stays 0.
- Strobe while busy: io_rd to 16'h1001 during WAIT → ignored, no re_1 pulse.
